jk_mod_counter: RTL and testbench

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

---
 rtl/jk_mod_counter.sv | 121 ++++++++++++
 tb/tb_jk_mod_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK flip-flops, stepped by the
// rising edges of an asynchronous divided-clock level, with parallel load,
// a one-cycle terminal-count pulse and an active-low seven-segment decode.
module jk_mod_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 10
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [6:0]       seg_n
);

   // One extra bit so MOD = 2^WIDTH is representable in the load range check.
   localparam int unsigned   CW    = WIDTH + 1;
   localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
   localparam logic [CW-1:0]    MOD_V = CW'(MOD);

   logic             s1, s2, s3;
   logic             step;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] j, k;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic [3:0]       nib;

   // Two-flop synchronizer for tick_in plus a history flop for edge detection.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tick_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign step = s2 & ~s3;

   // Select the value the count should take next; load wins over a step.
   always_comb begin
      target = count;
      tc_nxt = 1'b0;
      if (load) begin
         if ({1'b0, load_val} >= MOD_V) begin
            target = '0;
         end else begin
            target = load_val;
         end
      end else if (step && en) begin
         if (up_dn) begin
            if (count == TOP) begin
               target = '0;
               tc_nxt = 1'b1;
            end else begin
               target = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               target = TOP;
               tc_nxt = 1'b1;
            end else begin
               target = count - WIDTH'(1);
            end
         end
      end
   end

   // JK inputs: toggle a bit exactly where it differs from the target.
   always_comb begin
      j     = target ^ count;
      k     = target ^ count;
      q_nxt = (j & ~count) | (~k & count);
   end

   // Count JK flops and the registered terminal-count pulse.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= q_nxt;
         tc    <= tc_nxt;
      end
   end

   assign nib = 4'(count);

   // Active-low seven-segment decode of the count, bit order {g,f,e,d,c,b,a}.
   always_comb begin
      seg_n = 7'b1111111;
      case (nib)
         4'h0: seg_n = 7'b1000000;
         4'h1: seg_n = 7'b1111001;
         4'h2: seg_n = 7'b0100100;
         4'h3: seg_n = 7'b0110000;
         4'h4: seg_n = 7'b0011001;
         4'h5: seg_n = 7'b0010010;
         4'h6: seg_n = 7'b0000010;
         4'h7: seg_n = 7'b1111000;
         4'h8: seg_n = 7'b0000000;
         4'h9: seg_n = 7'b0010000;
         4'hA: seg_n = 7'b0001000;
         4'hB: seg_n = 7'b0000011;
         4'hC: seg_n = 7'b1000110;
         4'hD: seg_n = 7'b0100001;
         4'hE: seg_n = 7'b0000110;
         4'hF: seg_n = 7'b0001110;
         default: seg_n = 7'b1111111;
      endcase
   end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MOD=10).
module tb_jk_mod_counter;

   logic       clk_in;
   logic       rst_n;
   logic       tick_in;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic [6:0] seg_n;

   int total;
   int bad;

   logic [6:0] seg_tab [16];

   jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .tick_in  (tick_in),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .seg_n    (seg_n)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nedge(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Raise tick_in; three edges later the resulting step has been registered.
   task automatic tick_rise;
      tick_in = 1'b1;
      nedge(3);
   endtask

   task automatic tick_fall;
      tick_in = 1'b0;
      nedge(3);
   endtask

   task automatic do_load(input logic [3:0] v);
      load     = 1'b1;
      load_val = v;
      nedge(1);
      load     = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

      rst_n    = 1'b0;
      tick_in  = 1'b0;
      en       = 1'b1;
      up_dn    = 1'b1;
      load     = 1'b0;
      load_val = 4'd0;
      nedge(2);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_tc",    32'(tc),    32'd0);
      chk("rst_seg",   32'(seg_n), 32'b1000000);
      rst_n = 1'b1;
      nedge(2);

      // Up count through a full wrap.
      for (int i = 1; i <= 10; i++) begin
         tick_rise();
         chk("up_count", 32'(count), 32'(i % 10));
         chk("up_tc",    32'(tc),    (i == 10) ? 32'd1 : 32'd0);
         chk("up_seg",   32'(seg_n), 32'(seg_tab[i % 10]));
         tick_in = 1'b0;
         nedge(1);
         chk("up_tc_clr", 32'(tc), 32'd0);
         nedge(2);
      end

      // Down wrap from 0, then a plain decrement.
      up_dn = 1'b0;
      tick_rise();
      chk("dn_wrap_count", 32'(count), 32'd9);
      chk("dn_wrap_tc",    32'(tc),    32'd1);
      nedge(1);
      chk("dn_wrap_tc_clr", 32'(tc), 32'd0);
      tick_fall();
      tick_rise();
      chk("dn_count", 32'(count), 32'd8);
      chk("dn_tc",    32'(tc),    32'd0);
      tick_fall();

      // Latency: sampled at E0, count changes at E2; long high gives one step.
      up_dn   = 1'b1;
      tick_in = 1'b1;
      nedge(1);
      chk("lat_e0", 32'(count), 32'd8);
      nedge(1);
      chk("lat_e1", 32'(count), 32'd8);
      nedge(1);
      chk("lat_e2", 32'(count), 32'd9);
      nedge(50);
      chk("lat_hold", 32'(count), 32'd9);
      tick_fall();
      chk("lat_fall", 32'(count), 32'd9);

      // Load coincident with a step that would otherwise wrap with tc.
      tick_in = 1'b1;
      nedge(2);
      load     = 1'b1;
      load_val = 4'd7;
      nedge(1);
      load = 1'b0;
      chk("ld_step_count", 32'(count), 32'd7);
      chk("ld_step_tc",    32'(tc),    32'd0);
      tick_fall();
      chk("ld_no_queue", 32'(count), 32'd7);
      do_load(4'd12);
      chk("ld_12", 32'(count), 32'd0);
      do_load(4'd9);
      chk("ld_9", 32'(count), 32'd9);
      do_load(4'd10);
      chk("ld_10", 32'(count), 32'd0);
      chk("ld_10_tc", 32'(tc), 32'd0);

      // Down decrement from 1 to 0 gives no tc.
      do_load(4'd1);
      up_dn = 1'b0;
      tick_rise();
      chk("dn_1_count", 32'(count), 32'd0);
      chk("dn_1_tc",    32'(tc),    32'd0);
      tick_fall();
      up_dn = 1'b1;

      // Enable low swallows steps; raising it later replays nothing.
      do_load(4'd3);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_rise();
         chk("en0_count", 32'(count), 32'd3);
         if (i < 2) tick_fall();
      end
      en = 1'b1;
      nedge(5);
      chk("en1_hold_hi", 32'(count), 32'd3);
      tick_fall();
      chk("en1_hold_lo", 32'(count), 32'd3);

      // Asynchronous reset mid-step, then release with tick_in high.
      do_load(4'd5);
      chk("rst_pre", 32'(count), 32'd5);
      tick_in = 1'b1;
      nedge(1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_seg",   32'(seg_n), 32'b1000000);
      chk("arst_tc",    32'(tc),    32'd0);
      nedge(2);
      chk("arst_abort", 32'(count), 32'd0);
      rst_n = 1'b1;
      nedge(1);
      chk("rel_e0", 32'(count), 32'd0);
      nedge(2);
      chk("rel_step", 32'(count), 32'd1);
      chk("rel_seg",  32'(seg_n), 32'(seg_tab[1]));
      nedge(10);
      chk("rel_one", 32'(count), 32'd1);
      tick_fall();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
